// File: rtl/mmap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mmap_pkg
//  Purpose  : Address map, timeout and FSM encoding shared by bus_mmapper.
//  Revision : 1.0 - initial release
// ============================================================================
package mmap_pkg;

    localparam int NSLAVE = 4;
    localparam int SEL_W  = $clog2(NSLAVE);

    // Slave i occupies [REGION_BASE[i], REGION_LIMIT[i]] inclusive.
    localparam logic [NSLAVE-1:0][31:0] REGION_BASE  = {32'h9400_0000, 32'h9300_0000,
                                                        32'h2000_0000, 32'h0000_0000};
    localparam logic [NSLAVE-1:0][31:0] REGION_LIMIT = {32'h94FF_FFFF, 32'h9300_00FF,
                                                        32'h2FFF_FFFF, 32'h0000_FFFF};

    localparam int          TIMEOUT        = 1024;
    localparam int          CNT_W          = $clog2(TIMEOUT);
    localparam logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF;
    localparam logic [31:0] UNMAPPED_RDATA = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_GRACE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mmap_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mmap_decode
//  Purpose  : Combinational address decode to one-hot select, index, offset.
//  Revision : 1.0 - initial release
// ============================================================================
module mmap_decode
    import mmap_pkg::*;
(
    input  logic [31:0]       addr_i,
    output logic [NSLAVE-1:0] sel_o,
    output logic [SEL_W-1:0]  idx_o,
    output logic              hit_o,
    output logic [31:0]       offset_o
);

    logic [NSLAVE-1:0][31:0] w_off;

    // Unsigned wrap-around turns the two-sided range test into one compare.
    for (genvar i = 0; i < NSLAVE; i++) begin : g_region
        assign w_off[i] = addr_i - REGION_BASE[i];
        assign sel_o[i] = (w_off[i] <= (REGION_LIMIT[i] - REGION_BASE[i]));
    end

    always_comb begin
        idx_o    = '0;
        offset_o = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel_o[i]) begin
                idx_o    = SEL_W'(i);
                offset_o = w_off[i];
            end
        end
    end

    assign hit_o = |sel_o;

endmodule
`default_nettype wire

// File: rtl/bus_mmapper.sv
`default_nettype none
// ============================================================================
//  Module   : bus_mmapper
//  Purpose  : Routes one master request at a time to one of four slaves,
//             with unmapped-address and slave-timeout error responses.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_mmapper
    import mmap_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           a,
    input  logic [31:0]           d,
    input  logic                  we,
    input  logic                  rd,
    output logic [31:0]           spo,
    output logic                  ready,
    output logic [NSLAVE*32-1:0]  s_a,
    output logic [NSLAVE*32-1:0]  s_d,
    output logic [NSLAVE-1:0]     s_we,
    output logic [NSLAVE-1:0]     s_rd,
    input  logic [NSLAVE*32-1:0]  s_spo,
    input  logic [NSLAVE-1:0]     s_ready,
    output logic                  bus_err,
    output logic [31:0]           err_addr
);

    logic [NSLAVE-1:0] w_sel;
    logic [SEL_W-1:0]  w_idx;
    logic              w_hit;
    logic [31:0]       w_off;

    mmap_decode u_decode (
        .addr_i   (a),
        .sel_o    (w_sel),
        .idx_o    (w_idx),
        .hit_o    (w_hit),
        .offset_o (w_off)
    );

    state_t               state_q;
    logic                 is_wr_q;
    logic [SEL_W-1:0]     idx_q;
    logic [31:0]          addr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [31:0]          spo_q;
    logic                 ready_q;
    logic [NSLAVE*32-1:0] s_a_q;
    logic [NSLAVE*32-1:0] s_d_q;
    logic [NSLAVE-1:0]    s_we_q;
    logic [NSLAVE-1:0]    s_rd_q;
    logic                 bus_err_q;
    logic [31:0]          err_addr_q;

    logic                 w_sel_ready;
    logic [31:0]          w_sel_rdata;

    assign w_sel_ready = s_ready[idx_q];
    assign w_sel_rdata = s_spo[{idx_q, 5'd0} +: 32];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            is_wr_q    <= 1'b0;
            idx_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            spo_q      <= '0;
            ready_q    <= 1'b1;
            s_a_q      <= '0;
            s_d_q      <= '0;
            s_we_q     <= '0;
            s_rd_q     <= '0;
            bus_err_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            bus_err_q <= 1'b0;
            s_we_q    <= '0;
            s_rd_q    <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (rd || we) begin
                        is_wr_q <= we;
                        idx_q   <= w_idx;
                        addr_q  <= a;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        s_a_q   <= '0;
                        s_d_q   <= '0;
                        if (w_hit) begin
                            // Strobe is registered here so it is visible exactly during ISSUE.
                            s_a_q[{w_idx, 5'd0} +: 32] <= w_off;
                            s_d_q[{w_idx, 5'd0} +: 32] <= d;
                            if (we) s_we_q <= w_sel;
                            else    s_rd_q <= w_sel;
                            state_q <= ST_ISSUE;
                        end else begin
                            state_q <= ST_ERR;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_GRACE;
                ST_GRACE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (w_sel_ready) begin
                        if (!is_wr_q) spo_q <= w_sel_rdata;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        if (!is_wr_q) spo_q <= ERR_RDATA;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                        ready_q    <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_ERR: begin
                    if (!is_wr_q) spo_q <= UNMAPPED_RDATA;
                    bus_err_q  <= 1'b1;
                    err_addr_q <= addr_q;
                    ready_q    <= 1'b1;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign spo      = spo_q;
    assign ready    = ready_q;
    assign s_a      = s_a_q;
    assign s_d      = s_d_q;
    assign s_we     = s_we_q;
    assign s_rd     = s_rd_q;
    assign bus_err  = bus_err_q;
    assign err_addr = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_mmapper.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_mmapper
//  Purpose  : Self-checking bench for bus_mmapper against an address-map and
//             latency reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_mmapper;

    localparam int TO = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  a, d;
    logic         we, rd;
    logic [31:0]  spo;
    logic         ready;
    logic [127:0] s_a, s_d;
    logic [3:0]   s_we, s_rd;
    logic [127:0] s_spo;
    logic [3:0]   s_ready;
    logic         bus_err;
    logic [31:0]  err_addr;

    always #5 clk = ~clk;

    bus_mmapper dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .d        (d),
        .we       (we),
        .rd       (rd),
        .spo      (spo),
        .ready    (ready),
        .s_a      (s_a),
        .s_d      (s_d),
        .s_we     (s_we),
        .s_rd     (s_rd),
        .s_spo    (s_spo),
        .s_ready  (s_ready),
        .bus_err  (bus_err),
        .err_addr (err_addr)
    );

    int          n_total = 0;
    int          n_bad   = 0;
    logic [31:0] m_spo   = '0;
    logic [31:0] m_err   = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference address map: slave index (-1 = unmapped) and offset from region base.
    function automatic int ref_map(input logic [31:0] addr, output logic [31:0] off);
        off = '0;
        if (addr <= 32'h0000_FFFF) begin
            off = addr; return 0;
        end else if (addr >= 32'h2000_0000 && addr <= 32'h2FFF_FFFF) begin
            off = addr - 32'h2000_0000; return 1;
        end else if (addr >= 32'h9300_0000 && addr <= 32'h9300_00FF) begin
            off = addr - 32'h9300_0000; return 2;
        end else if (addr >= 32'h9400_0000 && addr <= 32'h94FF_FFFF) begin
            off = addr - 32'h9400_0000; return 3;
        end
        return -1;
    endfunction

    // op: 0 read, 1 write, 2 rd+we (write). wait_cyc: cycles the slave stays busy after the strobe.
    task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input int op,
                           input int wait_cyc, input logic [31:0] rdata, input bit hold_req);
        int          idx, wc, exp_edges, low, j, extra, unstable, early_err;
        bit          is_wr, tmo, done;
        logic [31:0] off;
        logic [7:0]  exp_st;
        logic [127:0] a_snap, d_snap;

        idx   = ref_map(addr, off);
        is_wr = (op != 0);
        tmo   = 1'b0;
        if (idx < 0) begin
            exp_edges = 2;
        end else begin
            wc = (wait_cyc > 1) ? wait_cyc - 1 : 1;
            if (wc > TO) begin
                tmo = 1'b1;
                wc  = TO;
            end
            exp_edges = 3 + wc;
        end

        s_spo = {$urandom, $urandom, $urandom, $urandom};
        if (idx >= 0) s_spo[idx*32 +: 32] = rdata;
        a  = addr;
        d  = wdata;
        we = (op != 0);
        rd = (op != 1);
        @(negedge clk);
        if (!hold_req) begin
            we = 1'b0;
            rd = 1'b0;
        end

        exp_st = '0;
        if (idx >= 0) exp_st[is_wr ? idx + 4 : idx] = 1'b1;
        check_eq("strobe", {s_we, s_rd}, exp_st);
        if (idx >= 0) begin
            check_eq("s_a_off", s_a[idx*32 +: 32], off);
            check_eq("s_d", s_d[idx*32 +: 32], wdata);
        end
        a_snap = s_a;
        d_snap = s_d;

        low = 0; j = 1; done = 1'b0; extra = 0; unstable = 0; early_err = 0;
        while (!done && j < 1200) begin
            if (ready) begin
                done = 1'b1;
            end else begin
                low++;
                if (j > 1 && (s_we | s_rd) != 4'b0) extra++;
                if (s_a != a_snap || s_d != d_snap) unstable++;
                if (bus_err) early_err++;
                if (idx >= 0) s_ready[idx] = (j - 1 >= wait_cyc);
                @(negedge clk);
                j++;
            end
        end
        we = 1'b0;
        rd = 1'b0;
        s_ready = 4'hF;
        check_eq("completed", done, 1);

        if (idx < 0) begin
            if (!is_wr) m_spo = 32'h0;
            m_err = addr;
        end else if (tmo) begin
            if (!is_wr) m_spo = 32'hFFFF_FFFF;
            m_err = addr;
        end else if (!is_wr) begin
            m_spo = rdata;
        end

        check_eq("latency_edges", low + 1, exp_edges);
        check_eq("extra_strobe", extra, 0);
        check_eq("addr_data_stable", unstable, 0);
        check_eq("early_err", early_err, 0);
        check_eq("bus_err_pulse", bus_err, (idx < 0) || tmo);
        check_eq("spo", spo, m_spo);
        check_eq("err_addr", err_addr, m_err);
        @(negedge clk);
        check_eq("bus_err_len", bus_err, 0);
        check_eq("idle_ready", ready, 1);
        check_eq("idle_strobe", {s_we, s_rd}, 0);
    endtask

    // Reset asserted after `stage` post-accept samples (1 = ISSUE with strobe visible, 3 = WAIT).
    task automatic reset_mid(input int stage);
        a  = 32'h2000_0100;
        d  = $urandom;
        rd = 1'b1;
        we = 1'b0;
        @(negedge clk);
        rd = 1'b0;
        s_ready[1] = 1'b0;
        repeat (stage - 1) @(negedge clk);
        check_eq("mid_busy", ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        s_ready = 4'hF;
        m_spo = '0;
        m_err = '0;
        check_eq("rst_ready", ready, 1);
        check_eq("rst_strobe", {s_we, s_rd}, 0);
        check_eq("rst_spo", spo, 0);
        check_eq("rst_err", bus_err, 0);
        @(negedge clk);
        check_eq("rst_no_resume", {ready, s_we, s_rd}, 9'h100);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] unmapped [8];
        logic [31:0] ad;
        int          r;

        unmapped = '{32'h0001_0000, 32'h1FFF_FFFF, 32'h3000_0000, 32'h9300_0100,
                     32'h92FF_FFFF, 32'h9500_0000, 32'hFFFF_FFFF, 32'h5000_0000};
        rst = 1'b1; a = '0; d = '0; we = 1'b0; rd = 1'b0;
        s_spo = '0; s_ready = 4'hF;
        repeat (3) @(negedge clk);
        check_eq("reset_ready", ready, 1);
        check_eq("reset_spo", spo, 0);
        check_eq("reset_strobe", {s_we, s_rd}, 0);
        check_eq("reset_s_a_d", {|s_a, |s_d}, 0);
        check_eq("reset_err", {bus_err, err_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(32'h2000_0010, 32'h0,  0, 0, 32'h1234_5678, 1'b0);
        run_txn(32'h9300_0004, 32'h41, 2, 0, 32'hDEAD_BEEF, 1'b0);
        run_txn(32'h5000_0000, 32'h0,  0, 0, 32'h0,         1'b0);
        run_txn(32'h9400_0020, 32'h0,  0, 2000, 32'h0,      1'b0);
        run_txn(32'h2000_0040, 32'h0,  0, 5, 32'hCAFE_0001, 1'b1);
        run_txn(32'h0000_FFFF, 32'h0,  0, 1025, 32'hA5A5_0003, 1'b0);
        run_txn(32'h2FFF_FFFF, 32'h77, 1, 1026, 32'h0,      1'b0);
        run_txn(32'h9300_00FF, 32'h0,  0, 1, 32'h0000_00FF, 1'b0);
        run_txn(32'h94FF_FFFF, 32'h0,  0, 0, 32'h9494_9494, 1'b0);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 4);
            case (r)
                0:       ad = $urandom & 32'h0000_FFFF;
                1:       ad = 32'h2000_0000 | ($urandom & 32'h0FFF_FFFF);
                2:       ad = 32'h9300_0000 | ($urandom & 32'h0000_00FF);
                3:       ad = 32'h9400_0000 | ($urandom & 32'h00FF_FFFF);
                default: ad = unmapped[$urandom_range(0, 7)];
            endcase
            run_txn(ad, $urandom, $urandom_range(0, 2), $urandom_range(0, 8), $urandom,
                    1'($urandom_range(0, 1)));
        end

        reset_mid(1);
        reset_mid(3);
        run_txn(32'h0000_1234, 32'h0, 0, 3, 32'h0BAD_F00D, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_mmapper.md
BUS_MMAPPER -- requirements
Module: bus_mmapper

Interface
REQ-001 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port a  input  32  arbitrated master byte address.
REQ-004 SHALL have port d  input  32  arbitrated master write data.
REQ-005 SHALL have ports we, rd  input  1 each  master write / read request.
REQ-006 SHALL have port spo  output  32  read data to arbitrator.
REQ-007 SHALL have port ready  output  1  high = idle, accepting a request.
REQ-008 SHALL have ports s_a, s_d  output  4x32 packed  per-slave offset address / write data (slave i at bits [32i+31:32i]).
REQ-009 SHALL have ports s_we, s_rd  output  4  per-slave one-cycle write / read strobes.
REQ-010 SHALL have port s_spo  input  4x32 packed  per-slave read data.
REQ-011 SHALL have port s_ready  input  4  per-slave ready (low while busy).
REQ-012 SHALL have ports bus_err  output  1  one-cycle error pulse; err_addr  output  32  address of last error.

Function
REQ-013 SHALL decode the address map: slave0 0x0000_0000-0x0000_FFFF (boot BRAM); slave1 0x2000_0000-0x2FFF_FFFF (main RAM); slave2 0x9300_0000-0x9300_00FF (UART); slave3 0x9400_0000-0x94FF_FFFF (timer/GPIO); anything else is unmapped.
REQ-014 SHALL accept a request only in IDLE when ready=1 and (rd|we)=1; (rd|we) while ready=0 SHALL be ignored.
REQ-015 SHALL treat rd=we=1 as a write; rd is ignored.
REQ-016 SHALL use FSM states IDLE, ISSUE, GRACE, WAIT, ERR.
REQ-017 On accept SHALL latch the op, select and offset (a minus region base), drive s_a/s_d of the selected slave, clear ready, and go to ISSUE (mapped) or ERR (unmapped).
REQ-018 ISSUE SHALL assert exactly one of s_rd/s_we for the selected slave for one cycle, then go to GRACE; non-selected strobes stay 0.
REQ-019 GRACE SHALL last one cycle without sampling s_ready, then go to WAIT.
REQ-020 WAIT SHALL complete on the first cycle in which s_ready[sel]=1: for a read, capture s_spo[sel] into spo; set ready=1; go to IDLE.
REQ-021 Minimum latency SHALL be ready low for exactly 4 cycles (accept edge through WAIT-complete edge) for a zero-wait slave.
REQ-022 s_a/s_d of the selected slave SHALL stay stable from ISSUE until completion.
REQ-023 A 10-bit counter SHALL run in WAIT; if s_ready[sel] is still 0 after 1024 WAIT cycles, SHALL abort: spo=0xFFFF_FFFF (read only), bus_err pulse, err_addr=latched a, ready=1, IDLE.
REQ-024 ERR SHALL last one cycle: spo=0x0000_0000 for reads, bus_err pulse, err_addr=latched a, ready=1, IDLE; no slave strobe.
REQ-025 Writes SHALL leave spo unchanged.
REQ-026 A new request SHALL be accepted on the first cycle ready=1 is visible (back-to-back allowed).

Reset
REQ-027 rst SHALL force IDLE within one clock: ready=1, spo=0, s_we=s_rd=0, s_a=s_d=0, bus_err=0, err_addr=0, counter=0.
REQ-028 rst asserted mid-transaction SHALL drop any pending strobe on that edge and abandon the transaction without response.

Structure
REQ-029 Package mmap_pkg SHALL hold NSLAVE=4, region base/limit constants, TIMEOUT=1024, ERR_RDATA=0xFFFF_FFFF, and the FSM state encoding.
REQ-030 A combinational sub-module mmap_decode SHALL map address -> one-hot select, hit, offset.

Verification
REQ-031 Read a=0x2000_0010, slave1 zero-wait, s_spo=0x1234_5678 -> s_rd[1] pulse with offset 0x10, ready low 4 cycles, spo=0x1234_5678.
REQ-032 Write a=0x9300_0004 d=0x41 with rd=we=1 -> only s_we[2] pulses, offset 0x4, s_d=0x41, spo unchanged.
REQ-033 Read a=0x5000_0000 -> no strobe, bus_err one pulse, err_addr=0x5000_0000, spo=0, ready low 2 cycles.
REQ-034 Slave3 holds s_ready=0 forever -> abort after 1024 WAIT cycles, spo=0xFFFF_FFFF, bus_err pulse.
REQ-035 Slave1 busy 5 cycles, rd re-asserted during busy -> single transaction only; rst in WAIT -> ready=1, strobes 0 next cycle.
